// File: rtl/img_mem_pkg.sv
// Shared definitions for image-memory clients: arbiter state encoding and
// default address/data widths of the DDR-style image memory.
package img_mem_pkg;

  localparam int IMG_ADDR_W = 19;
  localparam int IMG_DATA_W = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick: on a tie the requester that was
// not served last wins, otherwise the single active requester wins.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic valid,
  output logic winner
);

  assign valid  = req0 | req1;
  assign winner = (req0 & req1) ? ~last_gnt : req1;

endmodule

// File: rtl/img_mem_arbiter.sv
// Two-requester arbiter/sequencer for port A of the image memory: grants one
// request at a time, drives the memory, and waits on its ready handshake.
module img_mem_arbiter
  import img_mem_pkg::*;
#(
  parameter int          ADDR_W  = IMG_ADDR_W,
  parameter int          DATA_W  = IMG_DATA_W,
  parameter logic [7:0]  TIMEOUT = 8'd32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_q,
  input  logic              mem_ready_we,
  input  logic              mem_ready_re,
  output logic              busy
);

  logic [1:0] state;
  logic       gnt;
  logic       last_gnt;
  logic       cur_we;
  logic       err_flag;
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_inc;
  logic       arb_valid;
  logic       arb_winner;
  logic       ready;

  rr_arb2 u_arb (
    .req0     (req0),
    .req1     (req1),
    .last_gnt (last_gnt),
    .valid    (arb_valid),
    .winner   (arb_winner)
  );

  // Only the ready line matching the current operation counts.
  assign ready        = cur_we ? mem_ready_we : mem_ready_re;
  assign wait_cnt_inc = wait_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      last_gnt  <= 1'b1;
      cur_we    <= 1'b0;
      err_flag  <= 1'b0;
      wait_cnt  <= 8'd0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            gnt       <= arb_winner;
            mem_addr  <= arb_winner ? addr1 : addr0;
            mem_wdata <= arb_winner ? wdata1 : wdata0;
            cur_we    <= arb_winner ? we1 : we0;
            err_flag  <= 1'b0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= 8'd0;
          state    <= WAIT;
        end
        WAIT: begin
          // mem_addr is deliberately left untouched: the memory keys its
          // ready detection off a stable address.
          if (ready) begin
            if (!cur_we) begin
              if (gnt) rdata1 <= mem_q;
              else     rdata0 <= mem_q;
            end
            state <= DONE;
          end else if (wait_cnt_inc == TIMEOUT) begin
            err_flag <= 1'b1;
            state    <= DONE;
          end else begin
            wait_cnt <= wait_cnt_inc;
          end
        end
        DONE: begin
          last_gnt <= gnt;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_we = (state == ISSUE) & cur_we;
  assign busy   = (state != IDLE);
  assign done0  = (state == DONE) & ~gnt;
  assign done1  = (state == DONE) &  gnt;
  assign err0   = done0 & err_flag;
  assign err1   = done1 & err_flag;

endmodule
